ir_sequencer: RTL and testbench



---
 rtl/ir_sequencer.sv | 111 +++++++++++
 tb/tb_ir_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ir_sequencer.sv
// Fetch/execute sequencer driving the instruction register's load and bus-enable pins,
// the PC fetch strobes and the microcode ROM address.
module ir_sequencer #(
    parameter int TMAX = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        u_end,
    input  logic [1:0]  u_imm_sel,
    input  logic [15:0] ir_value,
    output logic        ir_load,
    output logic        ir_enl,
    output logic        ir_enh,
    output logic        pc_to_ar,
    output logic        pc_inc,
    output logic [2:0]  tstate,
    output logic [10:0] uaddr,
    output logic        halted,
    output logic        overrun,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {FETCH0, FETCH1, EXEC, HALTED} state_t;

    localparam logic [2:0] TLAST = 3'(TMAX);

    state_t      state;
    logic [2:0]  tstate_q;
    logic [15:0] count_q;
    logic        overrun_q;
    logic        retire;
    logic        unused_ir_low;

    // An instruction ends on its own u_end or is cut off at the last T-state.
    assign retire = (state == EXEC) && (u_end || (tstate_q == TLAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH0;
            tstate_q  <= 3'd0;
            count_q   <= 16'd0;
            overrun_q <= 1'b0;
        end else if (!stall) begin
            case (state)
                FETCH0: begin
                    state    <= FETCH1;
                    tstate_q <= 3'd1;
                end
                FETCH1: begin
                    state    <= EXEC;
                    tstate_q <= 3'd2;
                end
                EXEC: begin
                    if (tstate_q == TLAST && !u_end) begin
                        overrun_q <= 1'b1;
                    end
                    if (retire) begin
                        count_q  <= count_q + 16'd1;
                        tstate_q <= 3'd0;
                        state    <= halt_req ? HALTED : FETCH0;
                    end else begin
                        tstate_q <= tstate_q + 3'd1;
                    end
                end
                HALTED: begin
                    tstate_q <= 3'd0;
                    if (!halt_req) begin
                        state <= FETCH0;
                    end
                end
                default: begin
                    state    <= FETCH0;
                    tstate_q <= 3'd0;
                end
            endcase
        end
    end

    // Strobes are decoded from registered state and suppressed for the whole stalled cycle.
    always_comb begin
        ir_load  = 1'b0;
        ir_enl   = 1'b0;
        ir_enh   = 1'b0;
        pc_to_ar = 1'b0;
        pc_inc   = 1'b0;
        if (!stall) begin
            case (state)
                FETCH0: begin
                    pc_to_ar = 1'b1;
                    pc_inc   = 1'b1;
                end
                FETCH1: ir_load = 1'b1;
                EXEC: begin
                    ir_enl = (u_imm_sel == 2'b01);
                    ir_enh = (u_imm_sel == 2'b10);
                end
                default: ;
            endcase
        end
    end

    assign unused_ir_low = ^ir_value[7:0];
    assign tstate        = tstate_q;
    assign uaddr         = {ir_value[15:8], tstate_q};
    assign halted        = (state == HALTED);
    assign overrun       = overrun_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_ir_sequencer.sv
// Directed cycle vectors for ir_sequencer; expected outputs queued per cycle and checked by a monitor.
module tb_ir_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        u_end = 1'b0;
    logic [1:0]  u_imm_sel = 2'b00;
    logic [15:0] ir_value = 16'h0000;
    logic        ir_load, ir_enl, ir_enh, pc_to_ar, pc_inc, halted, overrun;
    logic [2:0]  tstate;
    logic [10:0] uaddr;
    logic [15:0] instr_count;

    ir_sequencer #(.TMAX(7)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
        .u_end(u_end), .u_imm_sel(u_imm_sel), .ir_value(ir_value),
        .ir_load(ir_load), .ir_enl(ir_enl), .ir_enh(ir_enh),
        .pc_to_ar(pc_to_ar), .pc_inc(pc_inc), .tstate(tstate), .uaddr(uaddr),
        .halted(halted), .overrun(overrun), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {ir_load, ir_enl, ir_enh, pc_to_ar, pc_inc, halted, overrun}
    localparam logic [6:0] SF0 = 7'b0001100;
    localparam logic [6:0] SF1 = 7'b1000000;
    localparam logic [6:0] SEX = 7'b0000000;
    localparam logic [6:0] SL  = 7'b0100000;
    localparam logic [6:0] SH  = 7'b0010000;
    localparam logic [6:0] SHL = 7'b0000010;
    localparam logic [6:0] OV  = 7'b0000001;

    typedef struct {
        string       nm;
        logic [6:0]  strb;
        logic [2:0]  ts;
        logic [10:0] ua;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic cyc(input string nm, input logic rs, input logic st, input logic hr,
                       input logic ue, input logic [1:0] sel, input logic [15:0] ir,
                       input logic [6:0] strb, input logic [2:0] ts, input logic [15:0] cnt);
        exp_t e;
        reset     = rs;
        stall     = st;
        halt_req  = hr;
        u_end     = ue;
        u_imm_sel = sel;
        ir_value  = ir;
        e.nm   = nm;
        e.strb = strb;
        e.ts   = ts;
        e.ua   = {ir[15:8], ts};
        e.cnt  = cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] got;
            e = exp_q.pop_front();
            got = {ir_load, ir_enl, ir_enh, pc_to_ar, pc_inc, halted, overrun};
            checks++;
            if (got !== e.strb || tstate !== e.ts || uaddr !== e.ua || instr_count !== e.cnt) begin
                failures++;
                $display("FAIL %s: got strb=%b ts=%0d uaddr=%h cnt=%h, want strb=%b ts=%0d uaddr=%h cnt=%h",
                         e.nm, got, tstate, uaddr, instr_count, e.strb, e.ts, e.ua, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        //   name          rs st hr ue sel    ir        strobes   ts  cnt
        cyc("reset_held",   1, 0, 0, 0, 2'b00, 16'h1234, SF0,      0, 16'd0);
        cyc("basic_f0",     0, 0, 0, 0, 2'b00, 16'h1234, SF0,      0, 16'd0);
        cyc("basic_f1",     0, 0, 0, 0, 2'b00, 16'h1234, SF1,      1, 16'd0);
        cyc("basic_t2",     0, 0, 0, 0, 2'b00, 16'h1234, SEX,      2, 16'd0);
        cyc("basic_t3_end", 0, 0, 0, 1, 2'b00, 16'h1234, SEX,      3, 16'd0);
        // Full-length instruction without u_end: overrun becomes visible after retirement.
        cyc("ovr_f0",       0, 0, 0, 0, 2'b00, 16'hA5C3, SF0,      0, 16'd1);
        cyc("ovr_f1",       0, 0, 0, 0, 2'b00, 16'hA5C3, SF1,      1, 16'd1);
        for (int t = 2; t <= 7; t++)
            cyc("ovr_exec",  0, 0, 0, 0, 2'b00, 16'hA5C3, SEX, 3'(t), 16'd1);
        cyc("ovr_f0_next",  0, 0, 0, 0, 2'b00, 16'h5A3C, SF0 | OV, 0, 16'd2);
        cyc("imm_f1",       0, 0, 0, 0, 2'b00, 16'h5A3C, SF1 | OV, 1, 16'd2);
        cyc("imm_low",      0, 0, 0, 0, 2'b01, 16'h5A3C, SL | OV,  2, 16'd2);
        cyc("imm_high",     0, 0, 0, 0, 2'b10, 16'h5A3C, SH | OV,  3, 16'd2);
        cyc("imm_rsvd",     0, 0, 0, 0, 2'b11, 16'h5A3C, SEX | OV, 4, 16'd2);
        cyc("imm_stall",    0, 1, 0, 1, 2'b01, 16'h5A3C, SEX | OV, 5, 16'd2);
        cyc("imm_stall2",   0, 1, 0, 1, 2'b10, 16'h5A3C, SEX | OV, 5, 16'd2);
        cyc("imm_end",      0, 0, 0, 1, 2'b00, 16'h5A3C, SEX | OV, 5, 16'd2);
        cyc("stall_f0",     0, 1, 0, 0, 2'b00, 16'hFF00, SEX | OV, 0, 16'd3);
        cyc("f0_resume",    0, 0, 1, 0, 2'b00, 16'hFF00, SF0 | OV, 0, 16'd3);
        // halt_req raised during fetch is honoured at the instruction boundary.
        cyc("halt_f1",      0, 0, 1, 0, 2'b00, 16'hFF00, SF1 | OV, 1, 16'd3);
        cyc("halt_t2_end",  0, 0, 1, 1, 2'b01, 16'hFF00, SL | OV,  2, 16'd3);
        cyc("halted_a",     0, 0, 1, 0, 2'b01, 16'hFF00, SHL | OV, 0, 16'd4);
        cyc("halted_b",     0, 0, 1, 1, 2'b10, 16'hFF00, SHL | OV, 0, 16'd4);
        cyc("halted_drop",  0, 0, 0, 0, 2'b00, 16'hFF00, SHL | OV, 0, 16'd4);
        cyc("unhalt_f0",    0, 0, 0, 0, 2'b00, 16'h0700, SF0 | OV, 0, 16'd4);
        cyc("c5_f1",        0, 0, 0, 0, 2'b00, 16'h0700, SF1 | OV, 1, 16'd4);
        cyc("c5_t2_end",    0, 0, 0, 1, 2'b00, 16'h0700, SEX | OV, 2, 16'd4);
        // Reset in the middle of EXEC aborts without counting.
        cyc("rst_f0",       0, 0, 0, 0, 2'b00, 16'h8100, SF0 | OV, 0, 16'd5);
        cyc("rst_f1",       0, 0, 0, 0, 2'b00, 16'h8100, SF1 | OV, 1, 16'd5);
        cyc("rst_t2",       0, 0, 0, 0, 2'b00, 16'h8100, SEX | OV, 2, 16'd5);
        cyc("rst_t3",       0, 0, 0, 0, 2'b00, 16'h8100, SEX | OV, 3, 16'd5);
        cyc("rst_t4_apply", 1, 0, 0, 1, 2'b00, 16'h8100, SEX | OV, 4, 16'd5);
        cyc("rst_after",    0, 0, 0, 0, 2'b00, 16'h8100, SF0,      0, 16'd0);
        cyc("wrap_f1",      0, 0, 0, 0, 2'b00, 16'h3300, SF1,      1, 16'd0);
        force dut.count_q = 16'hFFFF;
        cyc("wrap_t2",      0, 0, 0, 0, 2'b00, 16'h3300, SEX,      2, 16'hFFFF);
        release dut.count_q;
        cyc("wrap_t3_end",  0, 0, 0, 1, 2'b00, 16'h3300, SEX,      3, 16'hFFFF);
        cyc("wrap_f0",      0, 0, 0, 0, 2'b00, 16'h3300, SF0,      0, 16'h0000);
        cyc("wrap_f1_next", 0, 0, 0, 0, 2'b00, 16'h3300, SF1,      1, 16'h0000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
